// File: rtl/bp_io_mmio_responder_if.sv
// IO command/response channel between an IO CCE mem link and an MMIO responder.
// The master issues commands and accepts responses; the slave is the responder.
interface bp_io_mmio_responder_if #(
  parameter int paddr_width_p   = 40,
  parameter int dword_width_p   = 64,
  parameter int payload_width_p = 16
);
  logic                       io_cmd_v;
  logic                       io_cmd_yumi;
  logic                       io_cmd_wr;
  logic [paddr_width_p-1:0]   io_cmd_addr;
  logic [1:0]                 io_cmd_size;
  logic [payload_width_p-1:0] io_cmd_payload;
  logic [dword_width_p-1:0]   io_cmd_data;

  logic                       io_resp_v;
  logic                       io_resp_ready;
  logic                       io_resp_wr;
  logic [paddr_width_p-1:0]   io_resp_addr;
  logic [1:0]                 io_resp_size;
  logic [payload_width_p-1:0] io_resp_payload;
  logic [dword_width_p-1:0]   io_resp_data;
  logic                       io_resp_err;

  modport master (
    output io_cmd_v, io_cmd_wr, io_cmd_addr, io_cmd_size, io_cmd_payload, io_cmd_data,
    output io_resp_ready,
    input  io_cmd_yumi,
    input  io_resp_v, io_resp_wr, io_resp_addr, io_resp_size, io_resp_payload,
    input  io_resp_data, io_resp_err
  );

  modport slave (
    input  io_cmd_v, io_cmd_wr, io_cmd_addr, io_cmd_size, io_cmd_payload, io_cmd_data,
    input  io_resp_ready,
    output io_cmd_yumi,
    output io_resp_v, io_resp_wr, io_resp_addr, io_resp_size, io_resp_payload,
    output io_resp_data, io_resp_err
  );
endinterface

// File: rtl/bp_io_mmio_responder.sv
// Terminating MMIO responder: a bank of 64-bit registers plus a read-only
// free-running cycle counter, one IO command in flight, one response per command.
module bp_io_mmio_responder #(
  parameter int                       paddr_width_p   = 40,
  parameter int                       dword_width_p   = 64,
  parameter int                       payload_width_p = 16,
  parameter int                       num_regs_p      = 8,
  parameter logic [paddr_width_p-1:0] base_addr_p     = '0
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  bp_io_mmio_responder_if.slave   io
);

  localparam int idx_width_lp = (num_regs_p > 1) ? $clog2(num_regs_p) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RESP = 1'b1;

  logic [0:0]                 state_q, state_d;
  logic [dword_width_p-1:0]   counter_q;
  logic [dword_width_p-1:0]   regs_q [num_regs_p];

  logic                       resp_wr_q;
  logic [paddr_width_p-1:0]   resp_addr_q;
  logic [1:0]                 resp_size_q;
  logic [payload_width_p-1:0] resp_payload_q;
  logic [dword_width_p-1:0]   resp_data_q;
  logic                       resp_err_q;

  logic                       yumi;
  logic                       hit, isReg, isCnt, misaligned, cmdErr;
  logic [8:0]                 wordIdx;
  logic [idx_width_lp-1:0]    regIdx;
  logic [2:0]                 byteOff;
  logic [7:0]                 sizeMask, wrMask;
  logic [dword_width_p-1:0]   dataMask, readSrc, readData, wrData;

  assign yumi = (state_q == IDLE) && io.io_cmd_v;

  // Decode and data alignment are computed straight from the offered command
  // so the access can complete in the yumi cycle.
  always_comb begin
    hit      = io.io_cmd_addr[paddr_width_p-1:12] == base_addr_p[paddr_width_p-1:12];
    wordIdx  = io.io_cmd_addr[11:3];
    isReg    = wordIdx < 9'(num_regs_p);
    isCnt    = wordIdx == 9'(num_regs_p);
    regIdx   = io.io_cmd_addr[3 +: idx_width_lp];
    byteOff  = io.io_cmd_addr[2:0];
    sizeMask   = 8'h01;
    dataMask   = 64'h0000_0000_0000_00FF;
    misaligned = 1'b0;
    case (io.io_cmd_size)
      2'd0: begin
        sizeMask   = 8'h01;
        dataMask   = 64'h0000_0000_0000_00FF;
        misaligned = 1'b0;
      end
      2'd1: begin
        sizeMask   = 8'h03;
        dataMask   = 64'h0000_0000_0000_FFFF;
        misaligned = byteOff[0];
      end
      2'd2: begin
        sizeMask   = 8'h0F;
        dataMask   = 64'h0000_0000_FFFF_FFFF;
        misaligned = |byteOff[1:0];
      end
      default: begin
        sizeMask   = 8'hFF;
        dataMask   = 64'hFFFF_FFFF_FFFF_FFFF;
        misaligned = |byteOff;
      end
    endcase
    cmdErr   = !hit || misaligned || !(isReg || isCnt) || (io.io_cmd_wr && isCnt);
    readSrc  = isCnt ? counter_q : regs_q[regIdx];
    readData = (readSrc >> {byteOff, 3'b000}) & dataMask;
    wrMask   = 8'(sizeMask << byteOff);
    wrData   = io.io_cmd_data << {byteOff, 3'b000};
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (yumi) state_d = RESP;
      default: if (io.io_resp_ready) state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_q        <= IDLE;
      counter_q      <= '0;
      resp_wr_q      <= 1'b0;
      resp_addr_q    <= '0;
      resp_size_q    <= '0;
      resp_payload_q <= '0;
      resp_data_q    <= '0;
      resp_err_q     <= 1'b0;
      for (int r = 0; r < num_regs_p; r++) regs_q[r] <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_q + 1'b1;
      if (yumi) begin
        resp_wr_q      <= io.io_cmd_wr;
        resp_addr_q    <= io.io_cmd_addr;
        resp_size_q    <= io.io_cmd_size;
        resp_payload_q <= io.io_cmd_payload;
        resp_err_q     <= cmdErr;
        resp_data_q    <= (io.io_cmd_wr || cmdErr) ? '0 : readData;
        // Errored writes never reach the register file.
        if (io.io_cmd_wr && !cmdErr && isReg) begin
          for (int b = 0; b < 8; b++) begin
            if (wrMask[b]) regs_q[regIdx][8*b +: 8] <= wrData[8*b +: 8];
          end
        end
      end
    end
  end

  assign io.io_cmd_yumi     = yumi;
  assign io.io_resp_v       = (state_q == RESP);
  assign io.io_resp_wr      = resp_wr_q;
  assign io.io_resp_addr    = resp_addr_q;
  assign io.io_resp_size    = resp_size_q;
  assign io.io_resp_payload = resp_payload_q;
  assign io.io_resp_data    = resp_data_q;
  assign io.io_resp_err     = resp_err_q;

endmodule
